hack_seq: RTL and testbench
===========================

# hack_seq

Multi-cycle instruction sequencer for the Hack CPU. It owns the program counter and instruction register, fetches 16-bit instructions from ROM and performs M-operand reads and writes on RAM through req/ack handshakes. It strobes the A and D register loads and evaluates jump conditions. It sits between the memories and the existing combinational control unit `cu`, which decodes `ir` and drives the ALU datapath.

## Interface
- ADDR_W, 15, ROM/RAM address and PC width
- WORD_W, 16, instruction and data width
- WDOG_LIMIT, 255, maximum wait cycles on an ack (used only with the watchdog)
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  start/continue execution
- rom_req  out  1  instruction fetch request
- rom_addr  out  ADDR_W  fetch address (= pc)
- rom_ack  in  1  fetch complete; rom_data valid this cycle
- rom_data  in  WORD_W  instruction word
- ram_req  out  1  data memory request
- ram_we  out  1  1 = write, 0 = read
- ram_addr  out  ADDR_W  data address
- ram_wdata  out  WORD_W  write data
- ram_ack  in  1  data access complete; ram_rdata valid on reads
- ram_rdata  in  WORD_W  read data
- a_val  in  ADDR_W  current A register (low bits)
- alu_out  in  WORD_W  ALU result for the current ir
- alu_zr, alu_ng  in  1  ALU zero / negative flags
- ir  out  WORD_W  latched instruction, feeds `cu`
- m_val  out  WORD_W  latched RAM read operand
- pc  out  ADDR_W  program counter
- load_a, load_d  out  1  one-cycle register load strobes
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, FETCH, DECODE, MEM_RD, EXEC, MEM_WR, and ERR (ERR exists only with the watchdog).
- **IDLE**: all requests low. Moves to FETCH when run=1.
- **FETCH**: rom_req=1 and rom_addr=pc, both held stable until rom_ack. On ack, ir<=rom_data and the state moves to DECODE.
- **DECODE**, when ir[15]=0 (A-instruction):
  - load_a=1 for this cycle only; the datapath loads A from ir.
  - pc<=pc+1.
  - Next state is FETCH if run=1, otherwise IDLE.
- **DECODE**, when ir[15]=1: go to MEM_RD if ir[12]=1 (a-bit), otherwise to EXEC.
- **MEM_RD**:
  - ram_req=1, ram_we=0, ram_addr=a_val.
  - On ram_ack, m_val<=ram_rdata and the state moves to EXEC.
- **EXEC** (one cycle):
  - Strobes: load_a=ir[5], load_d=ir[4].
  - Write capture: if ir[3]=1, latch wr_addr<=a_val and wr_data<=alu_out.
  - Jump: taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr).
  - PC update: pc<=a_val if taken, otherwise pc+1. a_val is the pre-update A.
  - Next state: MEM_WR if ir[3]=1; otherwise FETCH if run=1, else IDLE.
- **MEM_WR**:
  - ram_req=1, ram_we=1, with the latched address and data.
  - On ram_ack, go to FETCH if run=1, otherwise IDLE.
- PC arithmetic is modulo 2^ADDR_W: 0x7FFF+1 wraps to 0x0000.
- Dropping run mid-instruction completes the current instruction, then the sequencer stops in IDLE.
- An ack is honoured only while the matching req is high. Stray acks are ignored.

## Timing
- Reset values: state=IDLE; pc, ir, m_val = 0; every req, we, load and err output = 0.
- Reset asserted mid-transaction: requests drop on the next edge with no completion. Memories must tolerate an abandoned request.
- With zero-wait memories (ack in the same cycle as req), instruction latency is:
  - A-instruction: 2 cycles.
  - C-instruction, no M access: 3 cycles.
  - C-instruction with M read: 4 cycles.
  - C-instruction with M write: 4 cycles.
  - C-instruction with both read and write: 5 cycles.
- Each wait cycle adds 1 cycle of latency.
- rom_req and ram_req are never high in the same cycle.
- Request outputs and address/data outputs are registered.

## Configuration
- Macro `HACK_SEQ_WATCHDOG_EN` defined:
  - A counter runs in FETCH, MEM_RD and MEM_WR.
  - Reaching WDOG_LIMIT cycles without an ack moves the sequencer to ERR.
  - In ERR: err=1, all requests low. Only reset exits.
- Macro undefined: the sequencer waits indefinitely, ERR and the counter are absent, and err is tied to 0.

## Structure
- Shared package `hack_pkg` holds:
  - the state enum;
  - ADDR_W and WORD_W defaults;
  - instruction bit-position constants: CINST=15, ABIT=12, DEST_A=5, DEST_D=4, DEST_M=3, JLT=2, JEQ=1, JGT=0.
- One sub-module, `hack_jump_eval`: combinational; inputs ir[2:0], alu_zr, alu_ng; output taken.

## Test plan
- Zero-wait ROM holding 0x0005, reset then run=1:
  - the 0x0005 fetch is acked in FETCH;
  - load_a pulses in the following DECODE cycle;
  - pc=1 after 2 cycles.
- C-instruction 0xFC10 (D=M), a_val=0x0010, RAM[0x10]=0x1234 with ack delayed 3 cycles: m_val=0x1234, load_d pulses in EXEC, total 7 cycles.
- C-instruction 0xE308 (M=D), a_val=0x0020, alu_out=0xBEEF: a write request with ram_addr=0x0020 and ram_wdata=0xBEEF, held until ack.
- JEQ instruction 0xE302 with alu_zr=1, a_val=0x0100: pc=0x0100. Same instruction with alu_zr=0: pc=old pc+1. Also pc=0x7FFF with no jump: pc wraps to 0x0000.
- Reset asserted in MEM_RD while waiting: the next cycle has ram_req=0, state IDLE, pc=0.
- With `HACK_SEQ_WATCHDOG_EN` and rom_ack held 0: err=1 after 255 cycles, all requests low, and err cleared by reset.

Source files
------------

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack instruction sequencer.
// The ERR state exists only when HACK_SEQ_WATCHDOG_EN is defined.
package hack_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_WORD_W = 16;

  localparam int CINST  = 15;
  localparam int ABIT   = 12;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int JLT    = 2;
  localparam int JEQ    = 1;
  localparam int JGT    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_MEM_RD,
    ST_EXEC,
    ST_MEM_WR
`ifdef HACK_SEQ_WATCHDOG_EN
    , ST_ERR
`endif
  } state_e;

`ifdef HACK_SEQ_WATCHDOG_EN
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction
`endif

endpackage

// File: rtl/hack_jump_eval.sv
// Jump condition evaluation from the three jump bits of a C-instruction.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [2:0] ir_jmp,
  input  logic       alu_zr,
  input  logic       alu_ng,
  output logic       taken
);

  always_comb begin
    taken = (ir_jmp[JLT] & alu_ng) |
            (ir_jmp[JEQ] & alu_zr) |
            (ir_jmp[JGT] & ~alu_ng & ~alu_zr);
  end

endmodule

// File: rtl/hack_seq.sv
// Multi-cycle Hack sequencer: owns pc/ir, fetches from ROM, reads/writes RAM.
// Optional ack watchdog enabled by defining HACK_SEQ_WATCHDOG_EN.
module hack_seq
  import hack_pkg::*;
#(
  parameter int ADDR_W     = HACK_ADDR_W,
  parameter int WORD_W     = HACK_WORD_W,
  parameter int WDOG_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [WORD_W-1:0] rom_data,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [WORD_W-1:0] ram_rdata,
  input  logic [ADDR_W-1:0] a_val,
  input  logic [WORD_W-1:0] alu_out,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [WORD_W-1:0] ir,
  output logic [WORD_W-1:0] m_val,
  output logic [ADDR_W-1:0] pc,
  output logic              load_a,
  output logic              load_d,
  output logic              err
);

  if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
    $error("WDOG_LIMIT must be at least 1");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] m_val_q, m_val_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WORD_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              rom_req_q, rom_req_d;
  logic              ram_req_q, ram_req_d;
  logic              ram_we_q, ram_we_d;
  logic              load_a_q, load_a_d;
  logic              load_d_q, load_d_d;
  logic              jump_taken;
  logic              rom_done, ram_done;
  state_e            after_instr;

`ifdef HACK_SEQ_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              err_q, err_d;
`endif

  hack_jump_eval u_jump_eval (
    .ir_jmp (ir_q[JLT:JGT]),
    .alu_zr (alu_zr),
    .alu_ng (alu_ng),
    .taken  (jump_taken)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    m_val_d     = m_val_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    load_a_d    = 1'b0;
    load_d_d    = 1'b0;
    rom_done    = rom_req_q & rom_ack;
    ram_done    = ram_req_q & ram_ack;
    after_instr = run ? ST_FETCH : ST_IDLE;

    case (state_q)
      ST_IDLE: if (run) state_d = ST_FETCH;
      ST_FETCH: begin
        if (rom_done) begin
          ir_d     = rom_data;
          load_a_d = ~rom_data[CINST];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!ir_q[CINST]) begin
          pc_d    = pc_q + ADDR_W'(1);
          state_d = after_instr;
        end else if (ir_q[ABIT]) begin
          ram_addr_d = a_val;
          state_d    = ST_MEM_RD;
        end else begin
          load_a_d = ir_q[DEST_A];
          load_d_d = ir_q[DEST_D];
          state_d  = ST_EXEC;
        end
      end
      ST_MEM_RD: begin
        if (ram_done) begin
          m_val_d  = ram_rdata;
          load_a_d = ir_q[DEST_A];
          load_d_d = ir_q[DEST_D];
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // a_val here is still the pre-update A; the strobed load lands on this edge.
        pc_d = jump_taken ? a_val : pc_q + ADDR_W'(1);
        if (ir_q[DEST_M]) begin
          ram_addr_d  = a_val;
          ram_wdata_d = alu_out;
          state_d     = ST_MEM_WR;
        end else begin
          state_d = after_instr;
        end
      end
      ST_MEM_WR: if (ram_done) state_d = after_instr;
      default: state_d = state_q;
    endcase

`ifdef HACK_SEQ_WATCHDOG_EN
    wdog_cnt_d = WDOG_W'(WDOG_LIMIT - 1);
    if (is_wait_state(state_q) && (state_d == state_q)) begin
      if (wdog_cnt_q == '0) state_d = ST_ERR;
      else wdog_cnt_d = wdog_cnt_q - 1'b1;
    end
    err_d = (state_d == ST_ERR);
`endif

    // Requests decode from the next state so they come out of flops.
    rom_req_d = (state_d == ST_FETCH);
    ram_req_d = (state_d == ST_MEM_RD) || (state_d == ST_MEM_WR);
    ram_we_d  = (state_d == ST_MEM_WR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      m_val_q     <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rom_req_q   <= 1'b0;
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      load_a_q    <= 1'b0;
      load_d_q    <= 1'b0;
`ifdef HACK_SEQ_WATCHDOG_EN
      wdog_cnt_q  <= WDOG_W'(WDOG_LIMIT - 1);
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      m_val_q     <= m_val_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rom_req_q   <= rom_req_d;
      ram_req_q   <= ram_req_d;
      ram_we_q    <= ram_we_d;
      load_a_q    <= load_a_d;
      load_d_q    <= load_d_d;
`ifdef HACK_SEQ_WATCHDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  assign rom_req   = rom_req_q;
  assign rom_addr  = pc_q;
  assign ram_req   = ram_req_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ir        = ir_q;
  assign m_val     = m_val_q;
  assign pc        = pc_q;
  assign load_a    = load_a_q;
  assign load_d    = load_d_q;
`ifdef HACK_SEQ_WATCHDOG_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_hack_seq.sv
// Directed bench for hack_seq: a vector table of single instructions run
// back to back, plus hand sequences for run drop, stray acks and reset.
module tb_hack_seq;

  logic        clk = 1'b0;
  logic        reset, run;
  logic        rom_req, rom_ack, ram_req, ram_we, ram_ack;
  logic [14:0] rom_addr, ram_addr, a_val, pc;
  logic [15:0] rom_data, ram_wdata, ram_rdata, alu_out, ir, m_val;
  logic        alu_zr, alu_ng, load_a, load_d, err;

  int          n_checks = 0;
  int          n_pass = 0;

  int          rom_delay = 0, ram_delay = 0;
  int          rom_wait = 0, ram_wait = 0;
  logic        stray_rom = 1'b0, stray_ram = 1'b0;
  logic [15:0] rom_word = '0, ram_word = '0;

  always #5 clk = ~clk;

  hack_seq dut (
    .clk(clk), .reset(reset), .run(run),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .a_val(a_val), .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .ir(ir), .m_val(m_val), .pc(pc), .load_a(load_a), .load_d(load_d), .err(err)
  );

  // Memory models: ack once the request has waited the programmed number of cycles.
  assign rom_ack   = (rom_req && (rom_wait >= rom_delay)) || stray_rom;
  assign ram_ack   = (ram_req && (ram_wait >= ram_delay)) || stray_ram;
  assign rom_data  = rom_word;
  assign ram_rdata = ram_word;

  always @(posedge clk) begin
    rom_wait <= (rom_req && !rom_ack) ? rom_wait + 1 : 0;
    ram_wait <= (ram_req && !ram_ack) ? ram_wait + 1 : 0;
  end

  typedef struct {
    logic [15:0] instr;
    logic [14:0] a;
    logic [15:0] alu;
    logic        zr;
    logic        ng;
    logic [15:0] rd;
    int          rom_dly;
    int          ram_dly;
    int          cyc;
    logic [14:0] pc;
    int          la_cyc;
    int          ld_cyc;
    logic        wr;
    logic [15:0] mval;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(logic [15:0] instr, logic [14:0] a, logic [15:0] alu,
                              logic zr, logic ng, logic [15:0] rd, int rdly, int wdly,
                              int cyc, logic [14:0] npc, int la, int ld, logic wr,
                              logic [15:0] mval);
    vec_t v;
    v.instr = instr; v.a = a; v.alu = alu; v.zr = zr; v.ng = ng; v.rd = rd;
    v.rom_dly = rdly; v.ram_dly = wdly; v.cyc = cyc; v.pc = npc;
    v.la_cyc = la; v.ld_cyc = ld; v.wr = wr; v.mval = mval;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered at the negedge of the first FETCH cycle; returns at the next one.
  task automatic run_vec(input int idx, input vec_t v);
    int   cyc, la_n, la_c, ld_n, ld_c, wr_n, hold_bad, overlap;
    logic prev;
    cyc = 0; la_n = 0; la_c = 0; ld_n = 0; ld_c = 0; wr_n = 0; hold_bad = 0; overlap = 0;
    rom_word = v.instr; a_val = v.a; alu_out = v.alu; alu_zr = v.zr; alu_ng = v.ng;
    ram_word = v.rd; rom_delay = v.rom_dly; ram_delay = v.ram_dly;
    do begin
      cyc++;
      if (load_a) begin la_n++; la_c = cyc; end
      if (load_d) begin ld_n++; ld_c = cyc; end
      if (rom_req && ram_req) overlap++;
      if (ram_req && ram_addr !== v.a) hold_bad++;
      if (ram_req && ram_we && ram_wdata !== v.alu) hold_bad++;
      if (ram_req && ram_we && ram_ack) wr_n++;
      prev = rom_req;
      @(negedge clk);
    end while (!(rom_req && !prev) && cyc < 60);
    chk($sformatf("v%0d cycles", idx), cyc, v.cyc);
    chk($sformatf("v%0d pc", idx), pc, v.pc);
    chk($sformatf("v%0d rom_addr", idx), rom_addr, v.pc);
    chk($sformatf("v%0d load_a pulses", idx), la_n, (v.la_cyc != 0) ? 1 : 0);
    chk($sformatf("v%0d load_a cycle", idx), la_c, v.la_cyc);
    chk($sformatf("v%0d load_d pulses", idx), ld_n, (v.ld_cyc != 0) ? 1 : 0);
    chk($sformatf("v%0d load_d cycle", idx), ld_c, v.ld_cyc);
    chk($sformatf("v%0d writes", idx), wr_n, v.wr ? 1 : 0);
    chk($sformatf("v%0d ram addr/data held", idx), hold_bad, 0);
    chk($sformatf("v%0d req overlap", idx), overlap, 0);
    if (v.instr[15] && v.instr[12]) chk($sformatf("v%0d m_val", idx), m_val, v.mval);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int n, seen, bad;
    //             instr     a_val     alu_out  zr ng rd      rdly wdly cyc pc        la ld wr mval
    vecs[0]  = mk(16'h0005, 15'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 2, 15'h0001, 2, 0, 0, 16'h0000);
    vecs[1]  = mk(16'hFC10, 15'h0010, 16'h1234, 0, 0, 16'h1234, 0, 3, 7, 15'h0002, 0, 7, 0, 16'h1234);
    vecs[2]  = mk(16'hE308, 15'h0020, 16'hBEEF, 0, 0, 16'h0000, 0, 2, 6, 15'h0003, 0, 0, 1, 16'h0000);
    vecs[3]  = mk(16'hE302, 15'h0100, 16'h0000, 1, 0, 16'h0000, 0, 0, 3, 15'h0100, 0, 0, 0, 16'h0000);
    vecs[4]  = mk(16'hE302, 15'h0200, 16'h0005, 0, 0, 16'h0000, 0, 0, 3, 15'h0101, 0, 0, 0, 16'h0000);
    vecs[5]  = mk(16'hE304, 15'h7FFF, 16'h8000, 0, 1, 16'h0000, 0, 0, 3, 15'h7FFF, 0, 0, 0, 16'h0000);
    vecs[6]  = mk(16'hE310, 15'h0040, 16'h0003, 0, 0, 16'h0000, 0, 0, 3, 15'h0000, 0, 3, 0, 16'h0000);
    vecs[7]  = mk(16'hE301, 15'h0123, 16'hFFFF, 0, 1, 16'h0000, 0, 0, 3, 15'h0001, 0, 0, 0, 16'h0000);
    vecs[8]  = mk(16'hE301, 15'h0333, 16'h0001, 0, 0, 16'h0000, 0, 0, 3, 15'h0333, 0, 0, 0, 16'h0000);
    vecs[9]  = mk(16'hFDC8, 15'h0050, 16'h0008, 0, 0, 16'h0007, 0, 0, 5, 15'h0334, 0, 0, 1, 16'h0007);
    vecs[10] = mk(16'hE038, 15'h0060, 16'h1111, 0, 0, 16'h0000, 0, 0, 4, 15'h0335, 3, 3, 1, 16'h0000);
    vecs[11] = mk(16'h1234, 15'h0000, 16'h0000, 0, 0, 16'h0000, 2, 0, 4, 15'h0336, 4, 0, 0, 16'h0000);

    reset = 1'b1; run = 1'b0; a_val = '0; alu_out = '0; alu_zr = 1'b0; alu_ng = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset rom_req", rom_req, 0);
    chk("reset ram_req", ram_req, 0);
    chk("reset ram_we", ram_we, 0);
    chk("reset pc", pc, 0);
    chk("reset ir", ir, 0);
    chk("reset m_val", m_val, 0);
    chk("reset loads", {load_a, load_d}, 0);
    chk("reset err", err, 0);

    reset = 1'b0; run = 1'b1;
    n = 0;
    while (!rom_req && n < 10) begin @(negedge clk); n++; end
    chk("idle to fetch", rom_req, 1);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Drop run during FETCH: instruction completes, then the sequencer parks in IDLE.
    rom_word = 16'hE310; a_val = '0; alu_zr = 1'b0; alu_ng = 1'b0; rom_delay = 0; ram_delay = 0;
    run = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin if (load_d) seen++; @(negedge clk); end
    chk("run drop pc", pc, 15'h0337);
    chk("run drop load_d", seen, 1);
    bad = 0;
    for (int k = 0; k < 5; k++) begin if (rom_req || ram_req) bad++; @(negedge clk); end
    chk("run drop idle reqs", bad, 0);

    // Acks with no request outstanding must change nothing.
    stray_rom = 1'b1; stray_ram = 1'b1; rom_word = 16'h0AAA; ram_word = 16'h5555;
    bad = 0;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (rom_req || ram_req) bad++; end
    stray_rom = 1'b0; stray_ram = 1'b0;
    chk("stray ack reqs", bad, 0);
    chk("stray ack ir", ir, 16'hE310);
    chk("stray ack m_val", m_val, 16'h0007);

    // Reset while MEM_RD is waiting on a slow RAM.
    rom_word = 16'hFC10; a_val = 15'h0010; ram_delay = 100; run = 1'b1;
    n = 0;
    while (!ram_req && n < 20) begin @(negedge clk); n++; end
    chk("mem_rd reached", ram_req, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1; run = 1'b0;
    @(negedge clk);
    chk("mid reset ram_req", ram_req, 0);
    chk("mid reset rom_req", rom_req, 0);
    chk("mid reset pc", pc, 0);
    chk("mid reset ir", ir, 0);
    chk("mid reset m_val", m_val, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post reset idle", rom_req, 0);
    run = 1'b1; ram_delay = 0;
    @(negedge clk);
    chk("restart fetch", rom_req, 1);
    chk("restart rom_addr", rom_addr, 0);
    chk("err low", err, 0);

`ifdef HACK_SEQ_WATCHDOG_EN
    reset = 1'b1; run = 1'b0; rom_delay = 100000;
    @(negedge clk);
    reset = 1'b0; run = 1'b1;
    n = 0;
    while (!rom_req && n < 10) begin @(negedge clk); n++; end
    chk("wdog fetch start", rom_req, 1);
    n = 0;
    while (!err && n < 400) begin @(negedge clk); n++; end
    chk("wdog cycles to err", n, 255);
    chk("wdog err", err, 1);
    chk("wdog reqs low", {rom_req, ram_req}, 0);
    repeat (3) @(negedge clk);
    chk("wdog err sticky", err, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("wdog err cleared", err, 0);
    reset = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
